// File: rtl/gate_bist.sv
// rtl/gate_bist.sv - self-test sequencer sweeping the four vectors of the two-input gate block
// Defining GATE_BIST_FAIL_CAPTURE_EN adds first-mismatch capture outputs (fail_valid/fail_vec/fail_y).
module gate_bist #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       in1,
    output logic       in2,
    input  logic [7:0] y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    ,
    output logic       fail_valid,
    output logic [1:0] fail_vec,
    output logic [7:0] fail_y
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // SETTLE counts down from S-1 to 0, so DRIVE+SETTLE+CHECK spans S+2 cycles
    localparam logic [3:0] SETTLE_LOAD = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

    state_t     state_q;
    logic [1:0] vec_q;
    logic [3:0] cnt_q;
    logic [2:0] err_q;
    logic       busy_q;
    logic       done_q;
    logic       pass_q;
    logic [7:0] golden;
    logic       mismatch;
    logic [2:0] err_d;

`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic       fail_valid_q;
    logic [1:0] fail_vec_q;
    logic [7:0] fail_y_q;
`endif

    always_comb begin
        golden = 8'h00;
        case (vec_q)
            2'b00:   golden = 8'hEC;
            2'b01:   golden = 8'h56;
            2'b10:   golden = 8'h96;
            default: golden = 8'h23;
        endcase
    end

    assign mismatch = (y_in != golden);
    assign err_d    = err_q + {2'b00, mismatch};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
            fail_valid_q <= 1'b0;
            fail_vec_q   <= 2'd0;
            fail_y_q     <= 8'h00;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= DRIVE;
                        vec_q   <= 2'd0;
                        err_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                        fail_valid_q <= 1'b0;
                        fail_vec_q   <= 2'd0;
                        fail_y_q     <= 8'h00;
`endif
                    end
                end
                DRIVE: begin
                    if (SETTLE_CYCLES == 0) begin
                        state_q <= CHECK;
                    end else begin
                        state_q <= SETTLE;
                        cnt_q   <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (cnt_q == 4'd0) state_q <= CHECK;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                CHECK: begin
                    err_q <= err_d;
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                    if (mismatch && !fail_valid_q) begin
                        fail_valid_q <= 1'b1;
                        fail_vec_q   <= vec_q;
                        fail_y_q     <= y_in;
                    end
`endif
                    // in1/in2 stay at the last vector once the sweep finishes
                    if (vec_q == 2'd3) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_d == 3'd0);
                    end else begin
                        state_q <= DRIVE;
                        vec_q   <= vec_q + 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in1       = vec_q[1];
    assign in2       = vec_q[0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

`ifdef GATE_BIST_FAIL_CAPTURE_EN
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
    assign fail_y     = fail_y_q;
`endif

endmodule

// File: tb/tb_gate_bist.sv
// tb/tb_gate_bist.sv - scoreboard bench for gate_bist with S=2 and S=0 instances
// Capture outputs are connected and checked when GATE_BIST_FAIL_CAPTURE_EN is defined.
module tb_gate_bist;

    typedef struct packed {
        logic [2:0] err;
        logic       pass;
        logic       fvalid;
        logic [1:0] fvec;
        logic [7:0] fy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_start = 1'b0, b_start = 1'b0;
    logic       a_in1, a_in2, b_in1, b_in2;
    logic [7:0] a_y, b_y;
    logic       a_busy, a_done, a_pass, b_busy, b_done, b_pass;
    logic [2:0] a_err, b_err;
    int         fault = 0;
    bit         use_b = 1'b0;
    int         n_cmp = 0;
    int         n_mis = 0;
    exp_t       sb_q[$];

`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic       a_fv, b_fv;
    logic [1:0] a_fvec, b_fvec;
    logic [7:0] a_fy, b_fy;
`endif

    always #5 clk = ~clk;

    function automatic logic [7:0] gate_model(input logic a, input logic b);
        return {~b, ~a, ~(a ^ b), a ^ b, ~(a | b), ~(a & b), a | b, a & b};
    endfunction

    function automatic logic [7:0] fault_apply(input logic [7:0] y, input int mode);
        if (mode == 1) return y & 8'hEF;
        if (mode == 2) return 8'h00;
        return y;
    endfunction

    assign a_y = fault_apply(gate_model(a_in1, a_in2), fault);
    assign b_y = fault_apply(gate_model(b_in1, b_in2), fault);

    gate_bist #(.SETTLE_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .in1(a_in1), .in2(a_in2), .y_in(a_y),
        .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err)
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        , .fail_valid(a_fv), .fail_vec(a_fvec), .fail_y(a_fy)
`endif
    );

    gate_bist #(.SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .in1(b_in1), .in2(b_in2), .y_in(b_y),
        .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err)
`ifdef GATE_BIST_FAIL_CAPTURE_EN
        , .fail_valid(b_fv), .fail_vec(b_fvec), .fail_y(b_fy)
`endif
    );

    logic       s_busy, s_done, s_pass;
    logic [2:0] s_err;
    logic [1:0] s_vec;
    assign s_busy = use_b ? b_busy : a_busy;
    assign s_done = use_b ? b_done : a_done;
    assign s_pass = use_b ? b_pass : a_pass;
    assign s_err  = use_b ? b_err  : a_err;
    assign s_vec  = use_b ? {b_in1, b_in2} : {a_in1, a_in2};
`ifdef GATE_BIST_FAIL_CAPTURE_EN
    logic       s_fv;
    logic [1:0] s_fvec;
    logic [7:0] s_fy;
    assign s_fv   = use_b ? b_fv   : a_fv;
    assign s_fvec = use_b ? b_fvec : a_fvec;
    assign s_fy   = use_b ? b_fy   : a_fy;
`endif

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t expect_sweep(input int mode);
        exp_t       e;
        logic [7:0] g, y;
        logic [1:0] v2;
        e = '0;
        for (int v = 0; v < 4; v++) begin
            v2 = v[1:0];
            g  = gate_model(v2[1], v2[0]);
            y  = fault_apply(g, mode);
            if (y != g) begin
                if (!e.fvalid) begin
                    e.fvalid = 1'b1;
                    e.fvec   = v2;
                    e.fy     = y;
                end
                e.err = e.err + 3'd1;
            end
        end
        e.pass = (e.err == 3'd0);
        return e;
    endfunction

    task automatic drive_start(input bit on_b, input logic val);
        if (on_b) b_start = val;
        else      a_start = val;
    endtask

    task automatic sweep(input bit on_b, input int mode, input int poke_at);
        int   s, last;
        exp_t e;
        s     = on_b ? 0 : 2;
        last  = 4 * (s + 2);
        use_b = on_b;
        fault = mode;
        @(negedge clk);
        drive_start(on_b, 1'b1);
        sb_q.push_back(expect_sweep(mode));
        @(negedge clk);
        for (int n = 0; n <= last; n++) begin
            drive_start(on_b, n == poke_at);
            chk("busy", s_busy, n < last);
            chk("done", s_done, n == last);
            if (n < last && (n % (s + 2)) == 0) chk("vec", s_vec, n / (s + 2));
            if (n == 0) begin
                chk("pass_clr", s_pass, 0);
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                chk("fv_clr", s_fv, 0);
`endif
            end
            if (n == last) begin
                chk("sb_size", sb_q.size(), 1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("err_count", s_err, e.err);
                    chk("pass", s_pass, e.pass);
`ifdef GATE_BIST_FAIL_CAPTURE_EN
                    chk("fail_valid", s_fv, e.fvalid);
                    chk("fail_vec", s_fvec, e.fvec);
                    chk("fail_y", s_fy, e.fy);
`endif
                end
            end
            if (n < last) @(negedge clk);
        end
        drive_start(on_b, 1'b0);
        @(negedge clk);
        chk("done_hold", s_done, 1);
        chk("vec_hold", s_vec, 3);
    endtask

    initial begin
        #1;
        chk("rst_busy_a", a_busy, 0);
        chk("rst_done_a", a_done, 0);
        chk("rst_pass_a", a_pass, 0);
        chk("rst_err_a", a_err, 0);
        chk("rst_vec_a", {a_in1, a_in2}, 0);
        chk("rst_busy_b", b_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        sweep(1'b0, 0, -1);
        sweep(1'b0, 1, -1);
        sweep(1'b0, 2, -1);
        sweep(1'b0, 0, -1);
        sweep(1'b0, 0, 5);

        // abort a sweep that already has one error recorded
        use_b = 1'b0;
        fault = 2;
        @(negedge clk);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_busy", a_busy, 1);
        rst = 1'b1;
        #1;
        chk("arst_busy", a_busy, 0);
        chk("arst_vec", {a_in1, a_in2}, 0);
        chk("arst_err", a_err, 0);
        chk("arst_done", a_done, 0);
        chk("arst_pass", a_pass, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep(1'b0, 0, -1);

        sweep(1'b1, 0, -1);
        sweep(1'b1, 1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
